// File: rtl/registrador_coluna_pkg.sv
// Shared mode and direction encodings for the column-select register.
package registrador_coluna_pkg;

  localparam logic [1:0] MODE_LOAD     = 2'b00;
  localparam logic [1:0] MODE_ROT_UP   = 2'b01;
  localparam logic [1:0] MODE_ROT_DOWN = 2'b10;
  localparam logic [1:0] MODE_BOUNCE   = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/divisor_passo.sv
// Step prescaler: counts enabled cycles modulo DIV and strobes on the terminal count.
// step is combinational from the count; clear holds the count at zero.
module divisor_passo #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign step = enable && !clear && (cnt == TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/registrador_coluna_parametrizado.sv
// Column-select register for the LED matrix scan: load, rotate up/down or bounce,
// advanced by a prescaled step, with lost-bit reinjection and registered step/wrap pulses.
module registrador_coluna_parametrizado
  import registrador_coluna_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ch1,
  input  logic             ch0,
  input  logic             enable,
  input  logic [WIDTH-1:0] valores_registrador,
  output logic [WIDTH-1:0] q,
  output logic             step_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE = ONE << (WIDTH - 1);

  logic [1:0]       mode;
  logic             is_load;
  logic             step;
  logic             dir;
  logic             dir_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign mode    = {ch1, ch0};
  assign is_load = (mode == MODE_LOAD);

  divisor_passo #(.DIV(DIV)) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (is_load),
    .enable  (enable),
    .step    (step)
  );

  // Next column pattern if a step happens this cycle.
  always_comb begin
    q_nxt    = q;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    if (q == '0) begin
      // Active bit was lost: reinject it at the edge the scan starts from.
      if (mode == MODE_ROT_DOWN) begin
        q_nxt = MSB_ONE;
      end else begin
        q_nxt   = ONE;
        dir_nxt = DIR_UP;
      end
    end else begin
      case (mode)
        MODE_ROT_UP: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          wrap_nxt = q[WIDTH-1];
        end
        MODE_ROT_DOWN: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          wrap_nxt = q[0];
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (q[WIDTH-1]) begin
              q_nxt    = q >> 1;
              dir_nxt  = DIR_DOWN;
              wrap_nxt = 1'b1;
            end else begin
              q_nxt = q << 1;
            end
          end else begin
            if (q[0]) begin
              q_nxt    = q << 1;
              dir_nxt  = DIR_UP;
              wrap_nxt = 1'b1;
            end else begin
              q_nxt = q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= ONE;
      dir    <= DIR_UP;
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end else if (is_load) begin
      q      <= valores_registrador;
      dir    <= DIR_UP;
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      step_o <= step;
      wrap_o <= step && wrap_nxt;
      if (step) begin
        q   <= q_nxt;
        dir <= dir_nxt;
      end
    end
  end

endmodule

// File: tb/tb_registrador_coluna_parametrizado.sv
// Bench for the column register: two instances (DIV=4 and DIV=1) driven in parallel,
// compared every cycle against a behavioural model, plus literal scenario expectations.
module tb_registrador_coluna_parametrizado;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ch1, ch0, en;
  logic [6:0] val;
  logic [6:0] q4, q1;
  logic       s4, w4, s1, w1;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = DIV 4 instance, index 1 = DIV 1 instance.
  logic [6:0] mq   [2];
  logic       mdir [2];
  int         mcnt [2];
  logic       mstep[2];
  logic       mwrap[2];

  always #5 clk = ~clk;

  registrador_coluna_parametrizado #(.WIDTH(7), .DIV(4)) u4 (
    .clk(clk), .reset_n(rst_n), .ch1(ch1), .ch0(ch0), .enable(en),
    .valores_registrador(val), .q(q4), .step_o(s4), .wrap_o(w4)
  );

  registrador_coluna_parametrizado #(.WIDTH(7), .DIV(1)) u1 (
    .clk(clk), .reset_n(rst_n), .ch1(ch1), .ch0(ch0), .enable(en),
    .valores_registrador(val), .q(q1), .step_o(s1), .wrap_o(w1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d] = 7'd1; mdir[d] = 1'b0; mcnt[d] = 0; mstep[d] = 1'b0; mwrap[d] = 1'b0;
    end
  endtask

  // Effect of one clock edge with the given inputs on model d (prescale div).
  task automatic model_update(input int d, input int div, input logic [1:0] m,
                              input logic e, input logic [6:0] v);
    logic [6:0] o;
    bit st;
    o = mq[d];
    mstep[d] = 1'b0;
    mwrap[d] = 1'b0;
    if (m == 2'd0) begin
      mq[d] = v; mcnt[d] = 0; mdir[d] = 1'b0;
    end else begin
      st = e && (((mcnt[d] + 1) % div) == 0);
      if (e) mcnt[d]++;
      mstep[d] = st;
      if (st) begin
        if (o == 7'd0) begin
          if (m == 2'd2) mq[d] = 7'h40;
          else begin mq[d] = 7'd1; mdir[d] = 1'b0; end
        end else if (m == 2'd1) begin
          mq[d] = (o << 1) | (o >> 6); mwrap[d] = o[6];
        end else if (m == 2'd2) begin
          mq[d] = (o >> 1) | (o << 6); mwrap[d] = o[0];
        end else if (mdir[d] == 1'b0) begin
          if (o[6]) begin mq[d] = o >> 1; mdir[d] = 1'b1; mwrap[d] = 1'b1; end
          else mq[d] = o << 1;
        end else begin
          if (o[0]) begin mq[d] = o << 1; mdir[d] = 1'b0; mwrap[d] = 1'b1; end
          else mq[d] = o >> 1;
        end
      end
    end
  endtask

  task automatic compare_models();
    check("div4_q",    int'(q4), int'(mq[0]));
    check("div4_step", int'(s4), int'(mstep[0]));
    check("div4_wrap", int'(w4), int'(mwrap[0]));
    check("div1_q",    int'(q1), int'(mq[1]));
    check("div1_step", int'(s1), int'(mstep[1]));
    check("div1_wrap", int'(w1), int'(mwrap[1]));
  endtask

  // Called at a negedge: drive inputs, advance model, sample at next negedge.
  task automatic cyc(input logic [1:0] m, input logic e, input logic [6:0] v);
    {ch1, ch0} = m; en = e; val = v;
    model_update(0, 4, m, e, v);
    model_update(1, 1, m, e, v);
    @(negedge clk);
    compare_models();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_models();
    rst_n = 1'b1;
  endtask

  initial begin
    int wraps;
    logic [6:0] bexp [13];
    rst_n = 1'b0; ch1 = 1'b0; ch0 = 1'b0; en = 1'b0; val = '0;
    model_reset();
    @(negedge clk);
    compare_models();
    check("rst_q", int'(q4), 1);
    check("rst_step", int'(s4), 0);
    check("rst_wrap", int'(w4), 0);
    rst_n = 1'b1;

    // LOAD ignores enable and never steps
    cyc(2'd0, 1'b1, 7'b1010101);
    check("load_q", int'(q4), 85);
    for (int i = 0; i < 4; i++) begin
      cyc(2'd0, i[0], 7'b1010101);
      check("load_step", int'(s4), 0);
    end

    // ROT_UP every 4 clocks, single wrap on 7th step
    cyc(2'd0, 1'b1, 7'd1);
    wraps = 0;
    for (int i = 1; i <= 28; i++) begin
      cyc(2'd1, 1'b1, 7'd0);
      if (w4) wraps++;
      if (i == 3)  check("rotup_nostep", int'(s4), 0);
      if (i == 4)  begin check("rotup_q1", int'(q4), 2); check("rotup_step1", int'(s4), 1); end
      if (i == 24) check("rotup_q6", int'(q4), 64);
      if (i == 28) begin check("rotup_q7", int'(q4), 1); check("rotup_wrap7", int'(w4), 1); end
    end
    check("rotup_wraps", wraps, 1);
    for (int i = 0; i < 10; i++) cyc(2'd1, 1'b0, 7'd0);
    check("freeze_q", int'(q4), 1);
    check("freeze_step", int'(s4), 0);
    for (int i = 1; i <= 4; i++) cyc(2'd1, 1'b1, 7'd0);
    check("resume_q", int'(q4), 2);

    // asynchronous reset mid-count, prescaler restarts
    cyc(2'd1, 1'b1, 7'd0);
    cyc(2'd1, 1'b1, 7'd0);
    #2 rst_n = 1'b0;
    #1 check("async_q", int'(q4), 1);
    model_reset();
    @(negedge clk);
    compare_models();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(2'd1, 1'b1, 7'd0);
      if (i == 3) check("restart_nostep", int'(s4), 0);
      if (i == 4) check("restart_q", int'(q4), 2);
    end

    // ROT_DOWN with lost-bit recovery
    cyc(2'd0, 1'b1, 7'd0);
    for (int i = 0; i < 4; i++) cyc(2'd2, 1'b1, 7'd0);
    check("recov_q", int'(q4), 64);
    check("recov_wrap", int'(w4), 0);
    check("recov_step", int'(s4), 1);
    for (int i = 0; i < 4; i++) cyc(2'd2, 1'b1, 7'd0);
    check("recov_next", int'(q4), 32);

    // BOUNCE on the DIV=1 instance
    bexp = '{7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64, 7'd32,
             7'd16, 7'd8, 7'd4, 7'd2, 7'd1, 7'd2};
    cyc(2'd0, 1'b1, 7'd1);
    for (int i = 0; i < 13; i++) begin
      cyc(2'd3, 1'b1, 7'd0);
      check("bounce_q", int'(q1), int'(bexp[i]));
      check("bounce_wrap", int'(w1), (i == 6 || i == 12) ? 1 : 0);
    end

    // DIV=1 rotate every clock, then reverse without prescaler reset
    cyc(2'd0, 1'b1, 7'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(2'd1, 1'b1, 7'd0);
      check("div1_step_hi", int'(s1), 1);
      check("div1_rot_q", int'(q1), 1 << i);
    end
    cyc(2'd2, 1'b1, 7'd0);
    check("div1_reverse", int'(q1), 16);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] m;
      logic [6:0] v;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        m = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        v = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
        cyc(m, ($urandom_range(0, 3) != 0), v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
